// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared types and defaults for clock-domain reset sequencers.
//   seq_state_t       - 2-bit sequencer state, encoding visible on debug ports
//   DEF_*_CYCLES      - default qualification / timeout / pulse lengths
package clk_rst_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2,
    ST_PLL_RST   = 2'd3
  } seq_state_t;

  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_PLL_RST_CYCLES = 16;

endpackage

// File: rtl/sync_bit.sv
// sync_bit: single-bit multi-flop synchroniser with async active-low reset.
//   clk, rst_n - destination clock / async reset (chain clears to 0)
//   d          - asynchronous input bit
//   q          - d after STAGES destination-clock flops
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: qualifies PLL lock and sequences the datapath reset.
//   clk           - free-running reference clock (not PLL-derived)
//   rst_n         - async active-low reset
//   locked_async  - raw PLL lock, asynchronous to clk
//   clear_counts  - sync pulse, zeroes both event counters (beats increments)
//   pll_rst       - PLL reset request, high for PLL_RST_CYCLES after a timeout
//   dp_rst_n      - datapath reset, high only in RUN
//   ready         - high only in RUN
//   loss_count    - saturating count of lock losses while in RUN
//   timeout_count - saturating count of lock timeouts
//   state         - current sequencer state (seq_state_t encoding)
module pll_reset_seq
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int CNT_W          = 17,
  parameter int EVT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_async,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             dp_rst_n,
  output logic             ready,
  output logic [EVT_W-1:0] loss_count,
  output logic [EVT_W-1:0] timeout_count,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [EVT_W-1:0] EVT_ONE      = EVT_W'(1);

  logic             lk;
  seq_state_t       st;
  logic [CNT_W-1:0] cnt;
  logic             loss_evt;
  logic             timeout_evt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked_async),
    .q     (lk)
  );

  // Event strobes mirror the FSM transitions below so the counters stay
  // in a separate, simpler block.
  assign loss_evt    = (st == ST_RUN) && !lk;
  assign timeout_evt = (st == ST_WAIT_LOCK) && !lk && (cnt == TIMEOUT_LAST);

  // Outputs are set on the transition into each state, so they are pure
  // flops with no path from lk or locked_async.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_WAIT_LOCK;
      cnt      <= '0;
      pll_rst  <= 1'b0;
      dp_rst_n <= 1'b0;
      ready    <= 1'b0;
    end else begin
      case (st)
        ST_WAIT_LOCK: begin
          if (lk) begin
            st  <= ST_STABLE;
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            st      <= ST_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // A dropout here is just an unqualified lock, not a loss.
          if (!lk) begin
            st  <= ST_WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st       <= ST_RUN;
            cnt      <= '0;
            dp_rst_n <= 1'b1;
            ready    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            st       <= ST_WAIT_LOCK;
            cnt      <= '0;
            dp_rst_n <= 1'b0;
            ready    <= 1'b0;
          end
        end
        ST_PLL_RST: begin
          // lk is meaningless while the PLL is held in reset.
          if (cnt == PLLRST_LAST) begin
            st      <= ST_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          st       <= ST_WAIT_LOCK;
          cnt      <= '0;
          pll_rst  <= 1'b0;
          dp_rst_n <= 1'b0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count    <= '0;
      timeout_count <= '0;
    end else if (clear_counts) begin
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (loss_evt && (loss_count != '1))
        loss_count <= loss_count + EVT_ONE;
      if (timeout_evt && (timeout_count != '1))
        timeout_count <= timeout_count + EVT_ONE;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed bench for pll_reset_seq with a cycle-indexed
// scoreboard. Expected output snapshots are queued with the cycle (posedge
// count since reset release) at which they must hold; each is popped and
// compared on the falling edge after that posedge.
module tb_pll_reset_seq;

  localparam int EVT_W = 4;
  localparam logic [1:0] WT = 2'd0, SB = 2'd1, RN = 2'd2, PR = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             locked_async = 1'b0;
  logic             clear_counts = 1'b0;
  logic             pll_rst, dp_rst_n, ready;
  logic [EVT_W-1:0] loss_count, timeout_count;
  logic [1:0]       state;

  pll_reset_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32),
    .PLL_RST_CYCLES(4), .CNT_W(17), .EVT_W(EVT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked_async(locked_async),
    .clear_counts(clear_counts), .pll_rst(pll_rst), .dp_rst_n(dp_rst_n),
    .ready(ready), .loss_count(loss_count), .timeout_count(timeout_count),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [1:0] st;
    logic       pll, dp, rdy;
    logic [3:0] lc, tc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic exp_at(input int c, input string tag, input logic [1:0] st,
                        input logic pll, input logic dp, input logic rdy,
                        input logic [3:0] lc, input logic [3:0] tc);
    exp_t e;
    e.cyc = c; e.tag = tag; e.st = st; e.pll = pll; e.dp = dp; e.rdy = rdy;
    e.lc = lc; e.tc = tc;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      assert ({state, pll_rst, dp_rst_n, ready, loss_count, timeout_count} ===
              {e.st, e.pll, e.dp, e.rdy, e.lc, e.tc})
      else begin
        n_fail++;
        $error("FAIL %s cyc=%0d got st=%0d pll=%b dp=%b rdy=%b loss=%0d to=%0d want st=%0d pll=%b dp=%b rdy=%b loss=%0d to=%0d",
               e.tag, cyc, state, pll_rst, dp_rst_n, ready, loss_count, timeout_count,
               e.st, e.pll, e.dp, e.rdy, e.lc, e.tc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_due();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Synchronous-style reset for scenario starts; checks the reset state.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; locked_async = 1'b0; clear_counts = 1'b0;
    repeat (3) @(negedge clk);
    cyc = 0;
    exp_at(0, "reset_state", WT, 0, 0, 0, 0, 0);
    check_due();
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    logic [3:0] lexp;

    // ---- Clean lock: release 10 edges after locked_async is captured ----
    do_reset();
    exp_at(6,  "clean_wait",   WT, 0, 0, 0, 0, 0);
    exp_at(7,  "clean_stable", SB, 0, 0, 0, 0, 0);
    exp_at(14, "clean_hold",   SB, 0, 0, 0, 0, 0);
    exp_at(15, "clean_run",    RN, 0, 1, 1, 0, 0);
    exp_at(40, "clean_stay",   RN, 0, 1, 1, 0, 0);
    run_to(4); locked_async = 1'b1;
    run_to(40);

    // ---- Glitchy lock, then loss in RUN and re-lock ----
    do_reset();
    exp_at(9,  "glitch_stable", SB, 0, 0, 0, 0, 0);
    exp_at(10, "glitch_drop",   WT, 0, 0, 0, 0, 0);
    exp_at(11, "glitch_wait",   WT, 0, 0, 0, 0, 0);
    exp_at(12, "glitch_relock", SB, 0, 0, 0, 0, 0);
    exp_at(19, "glitch_hold",   SB, 0, 0, 0, 0, 0);
    exp_at(20, "glitch_run",    RN, 0, 1, 1, 0, 0);
    exp_at(26, "loss_pre",      RN, 0, 1, 1, 0, 0);
    exp_at(27, "loss_assert",   WT, 0, 0, 0, 1, 0);
    exp_at(40, "loss_relock",   SB, 0, 0, 0, 1, 0);
    exp_at(41, "loss_rerun",    RN, 0, 1, 1, 1, 0);
    run_to(4);  locked_async = 1'b1;
    run_to(7);  locked_async = 1'b0;
    run_to(9);  locked_async = 1'b1;
    run_to(24); locked_async = 1'b0;
    run_to(30); locked_async = 1'b1;
    run_to(41);

    // ---- Timeout: two PLL reset pulses; lk ignored during the second ----
    do_reset();
    exp_at(31, "to_wait",      WT, 0, 0, 0, 0, 0);
    exp_at(32, "to1_start",    PR, 1, 0, 0, 0, 1);
    exp_at(35, "to1_end",      PR, 1, 0, 0, 0, 1);
    exp_at(36, "to1_exit",     WT, 0, 0, 0, 0, 1);
    exp_at(67, "to2_wait",     WT, 0, 0, 0, 0, 1);
    exp_at(68, "to2_start",    PR, 1, 0, 0, 0, 2);
    exp_at(71, "to2_lk_ign",   PR, 1, 0, 0, 0, 2);
    exp_at(72, "to2_exit",     WT, 0, 0, 0, 0, 2);
    exp_at(73, "to2_stable",   SB, 0, 0, 0, 0, 2);
    exp_at(81, "to2_run",      RN, 0, 1, 1, 0, 2);
    run_to(68); locked_async = 1'b1;
    run_to(81);

    // ---- Loss saturation, clear vs increment, async reset mid-RUN ----
    do_reset();
    exp_at(15, "sat_first_run", RN, 0, 1, 1, 0, 0);
    run_to(4); locked_async = 1'b1;
    run_to(15);
    c = 16;
    for (int i = 0; i < 20; i++) begin
      lexp = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      exp_at(c + 3,  "sat_loss",  WT, 0, 0, 0, lexp, 0);
      exp_at(c + 14, "sat_rerun", RN, 0, 1, 1, lexp, 0);
      run_to(c);      locked_async = 1'b0;
      run_to(c + 3);  locked_async = 1'b1;
      run_to(c + 14);
      c += 16;
    end
    exp_at(c + 3,  "clear_vs_loss", WT, 0, 0, 0, 0, 0);
    exp_at(c + 14, "clear_rerun",   RN, 0, 1, 1, 0, 0);
    exp_at(c + 19, "post_clear",    WT, 0, 0, 0, 1, 0);
    exp_at(c + 30, "post_rerun",    RN, 0, 1, 1, 1, 0);
    run_to(c);      locked_async = 1'b0;
    run_to(c + 2);  clear_counts = 1'b1;
    run_to(c + 3);  clear_counts = 1'b0; locked_async = 1'b1;
    run_to(c + 16); locked_async = 1'b0;
    run_to(c + 19); locked_async = 1'b1;
    run_to(c + 30);

    // Assert reset between edges; outputs must clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    exp_at(cyc, "async_rst", WT, 0, 0, 0, 0, 0);
    check_due();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    exp_at(2,  "rerel_wait",   WT, 0, 0, 0, 0, 0);
    exp_at(10, "rerel_stable", SB, 0, 0, 0, 0, 0);
    exp_at(11, "rerel_run",    RN, 0, 1, 1, 0, 0);
    run_to(11);

    n_checks++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL sb_drain got %0d pending want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
